seq_mult_ctrl: RTL
==================

Name: seq_mult_ctrl

Overview:
Sequencing controller and register datapath for the ALU's unsigned shift-add multiplier. It accepts a start request with two WIDTH-bit operands and runs one add/shift iteration per clock using a (WIDTH+1)-bit adder result. It then returns a 2*WIDTH-bit product with a one-cycle done pulse. It sits beside the combinational ALU ops (and/or/add/...) and is selected by the ALU's multiply opcode.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden by users).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand, captured when start is accepted
b  input  WIDTH  multiplier, captured when start is accepted
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  result register, held until next accepted start completes

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset (reset=1 at a rising edge): state=IDLE, busy=0, done=0, product=0, counter=0, internal multiplicand/accumulator registers=0. Reset overrides start and aborts any operation in flight; product is cleared, no done pulse.
- Arithmetic: unsigned only. Internal regs: mcand[WIDTH], acc[2*WIDTH], carry[1], cnt[CNT_W].
- FSM states:
  - IDLE: if start=1, load mcand=a, acc={WIDTH'b0,b}, cnt=0 and go to CALC. If start=0, stay in IDLE.
  - CALC: one iteration per cycle. If acc[0]=1, sum={1'b0,acc[2W-1:W]}+{1'b0,mcand}, else sum={1'b0,acc[2W-1:W]}. Then acc={sum,acc[W-1:1]} (logical right shift of the 2W+1-bit value) and cnt=cnt+1. On the iteration where cnt==WIDTH-1, product gets the post-shift acc and the state goes to DONE.
  - DONE: done=1 for this cycle only; unconditional transition to IDLE.
- Latency: start high in cycle c (IDLE). CALC occupies cycles c+1..c+WIDTH. done=1 in cycle c+WIDTH+1 (c+33 for WIDTH=32). The next start is accepted in cycle c+WIDTH+2 at the earliest.
- start while busy (CALC or DONE) is ignored, not queued; a/b changes while busy have no effect.
- product changes only at the CALC->DONE transition or on reset; it is stable from done until the next operation's done.
- done and busy are registered state decodes (no combinational path from start).
- Counter never wraps: it is compared against WIDTH-1 and cleared on load.

Optional Feature:
Macro ZERO_BYPASS_EN.
- Defined: in IDLE, if start=1 and (a==0 or b==0), go directly to DONE with product=0. done appears in cycle c+1 and CALC is skipped.
- Undefined: zero operands take the full WIDTH-iteration path (product=0, done at c+WIDTH+1).
- Non-zero operands behave identically in both builds.

Test Plan:
- Reset for 2 cycles, then release -> busy=0, done=0, product=0; idle for 5 cycles, done stays 0.
- start with a=3, b=5 in cycle c -> busy=1 in c+1..c+33; done=1 only in c+33; product=0x0000_0000_0000_000F held afterwards.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001 at done; carry path exercised.
- start with a=7, b=9; pulse start with a=2, b=2 at c+10 and again in the DONE cycle -> both ignored; product=63; a new start in c+34 is accepted and gives a=2, b=2 -> 4 at c+67.
- Assert reset at c+15 of a=0x1234, b=0x10 run -> next cycle IDLE, busy=0, product=0, no done pulse; a fresh start then completes normally with 0x12340.
- a=0, b=0xABCD -> with ZERO_BYPASS_EN: done at c+1, product=0; without: done at c+33, product=0.

Source files
------------

// File: rtl/seq_mult_ctrl_if.sv
// Request/response bundle for the sequential shift-add multiplier:
// start and operands toward the multiplier, busy/done/product back.
interface seq_mult_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Unsigned shift-add multiplier sequencer: one add/shift iteration per clock.
// Optional build macro ZERO_BYPASS_EN: zero operands skip CALC and finish in one cycle.
module seq_mult_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    seq_mult_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [PW-1:0]    product_q;

    logic [WIDTH:0]   sum_c;
    logic [PW-1:0]    acc_next_c;

    // One iteration: conditionally add the multiplicand to the upper half, then shift the carry in.
    always_comb begin
        sum_c = {1'b0, acc[PW-1:WIDTH]};
        if (acc[0]) begin
            sum_c = {1'b0, acc[PW-1:WIDTH]} + {1'b0, mcand};
        end
        acc_next_c = {sum_c, acc[WIDTH-1:1]};
    end

`ifdef ZERO_BYPASS_EN
    logic zero_op_c;
    always_comb begin
        zero_op_c = (bus.a == '0) || (bus.b == '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
`ifdef ZERO_BYPASS_EN
                        if (zero_op_c) begin
                            product_q <= '0;
                            state     <= DONE;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            mcand  <= bus.a;
                            acc    <= {WIDTH'(0), bus.b};
                            cnt    <= '0;
                            state  <= CALC;
                            busy_q <= 1'b1;
                        end
`else
                        mcand  <= bus.a;
                        acc    <= {WIDTH'(0), bus.b};
                        cnt    <= '0;
                        state  <= CALC;
                        busy_q <= 1'b1;
`endif
                    end
                end
                CALC: begin
                    acc <= acc_next_c;
                    cnt <= cnt + CNT_W'(1);
                    // Last iteration publishes the post-shift accumulator.
                    if (cnt == LAST_ITER) begin
                        product_q <= acc_next_c;
                        state     <= DONE;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
